// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared FSM encoding, region decode and grant codes for the memory bus arbiter
package mem_bus_arbiter_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_PWAIT, S_RESP} state_t;
    localparam int REGION_W = 3;
    localparam logic [REGION_W-1:0] REGION_RAM = 3'b000;
    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;
    function automatic logic is_ram(input logic [REGION_W-1:0] region);
        return region == REGION_RAM;
    endfunction
endpackage

// File: rtl/mem_bus_arbiter_grant.sv
// mem_bus_arbiter_grant: A-priority winner selection with a starvation counter that forces B through
module mem_bus_arbiter_grant
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a_req,
    input  logic b_req,
    input  logic idle,
    output logic win
);
    logic [3:0] starve_cnt;
    logic       full;

    assign full = starve_cnt == 4'(STARVE_LIMIT);
    assign win  = (b_req & (~a_req | full)) ? GNT_B : GNT_A;

    // count A wins taken while B waits; only the accepting IDLE cycle updates it
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (idle)
            starve_cnt <= (~b_req | win == GNT_B) ? '0 : (a_req & ~full) ? starve_cnt + 4'd1 : starve_cnt;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master RAM/peripheral bus arbiter; optional peripheral timeout via MEM_ARB_TIMEOUT_EN
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int RAM_LATENCY    = 1,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic                a_ack,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_err,
    input  logic                b_req,
    input  logic                b_we,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic                b_ack,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_err,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [REGION_W-1:0] per_sel,
    output logic [ADDR_W-4:0]   per_addr,
    output logic [DATA_W-1:0]   per_wdata,
    output logic                per_we,
    output logic                per_valid,
    input  logic                per_ready,
    input  logic [DATA_W-1:0]   per_rdata,
    output logic                busy,
    output logic                grant
);
    state_t              state, nxt;
    logic                win, lwe, gnt, pdone, hs, is_r, wdone, tmo;
    logic [ADDR_W-1:0]   laddr;
    logic [DATA_W-1:0]   lwdata, pcap, rd;
    logic [2:0]          wcnt;
    logic [REGION_W-1:0] region;

    if (RAM_LATENCY < 0 || RAM_LATENCY > 7 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("mem_bus_arbiter: parameter out of range");
    end

    mem_bus_arbiter_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .clk   (clk),
        .rst   (rst),
        .a_req (a_req),
        .b_req (b_req),
        .idle  (state == S_IDLE),
        .win   (win)
    );

    assign region = laddr[ADDR_W-1 -: REGION_W];
    assign is_r   = is_ram(region);
    assign hs     = per_valid & per_ready;
    assign wdone  = int'(wcnt) == RAM_LATENCY - 1;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          err_q;

    assign tmo   = (state == S_PWAIT) & ~pdone & ~per_ready & (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign a_err = err_q & (gnt == GNT_A);
    assign b_err = err_q & (gnt == GNT_B);

    // peripheral wait counter runs only in PWAIT; error flag is set as RESP is entered
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            tcnt <= (state == S_PWAIT) ? tcnt + TW'(1) : '0;
            if (nxt == S_RESP)
                err_q <= tmo;
        end
    end
`else
    assign tmo   = 1'b0;
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    // next state: RAM path waits a fixed latency, peripheral path waits for the handshake
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = (a_req | b_req) ? S_ISSUE : S_IDLE;
            S_ISSUE: nxt = ~is_r ? S_PWAIT : (RAM_LATENCY == 0) ? S_RESP : S_WAIT;
            S_WAIT:  nxt = wdone ? S_RESP : S_WAIT;
            S_PWAIT: nxt = (pdone | tmo) ? S_RESP : S_PWAIT;
            S_RESP:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // request latch, wait counting, peripheral capture and response data
    always_ff @(posedge clk) begin
        if (rst) begin
            laddr  <= '0;
            lwdata <= '0;
            lwe    <= 1'b0;
            gnt    <= GNT_A;
            wcnt   <= '0;
            pdone  <= 1'b0;
            pcap   <= '0;
            rd     <= '0;
        end else begin
            if (state == S_IDLE && (a_req | b_req)) begin
                laddr  <= win ? b_addr : a_addr;
                lwdata <= win ? b_wdata : a_wdata;
                lwe    <= win ? b_we : a_we;
                gnt    <= win;
            end
            wcnt  <= (state == S_WAIT) ? wcnt + 3'd1 : '0;
            pdone <= (state == S_IDLE) ? 1'b0 : pdone | hs;
            if (hs)
                pcap <= per_rdata;
            if (nxt == S_RESP)
                rd <= (lwe | tmo) ? '0 : is_r ? ram_rdata : pcap;
        end
    end

    assign busy      = state != S_IDLE;
    assign grant     = gnt;
    assign a_ack     = (state == S_RESP) & (gnt == GNT_A);
    assign b_ack     = (state == S_RESP) & (gnt == GNT_B);
    assign a_rdata   = rd;
    assign b_rdata   = rd;
    assign ram_addr  = laddr;
    assign ram_wdata = lwdata;
    assign ram_we    = (state == S_ISSUE) & is_r & lwe;
    assign per_sel   = region;
    assign per_addr  = laddr[ADDR_W-4:0];
    assign per_wdata = lwdata;
    assign per_we    = lwe & ~is_r;
    assign per_valid = (state == S_ISSUE || state == S_PWAIT) & ~is_r & ~pdone;
endmodule
